mem_port_arbiter: RTL and testbench

Shares one external memory bus between instruction fetch (I) and the load/store path fed by the execute stage (D).
- Bus protocol is req/gnt address phase followed by an in-order rvalid response phase.
- Arbitration: D has fixed priority, with a starvation guard for I.
- An outstanding-transaction ID FIFO routes each response back to the requester that issued it.
- Sits between the core's fetch/memory stages and the single SoC bus port.

---
 rtl/mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one req/gnt + in-order rvalid memory bus between the
//             instruction fetch port (I) and the load/store port (D).
//             D has fixed priority. I is forced to win once it has lost
//             STARVE_LIMIT consecutive cycles to D. An ID FIFO remembers
//             the owner of every granted transaction so that each in-order
//             response is steered back to the requester that issued it.
//  Revision : 1.0 - initial release
//
//  Optional : define ARB_PERF_COUNTERS_EN to add the grant and conflict
//             performance counters (perf_*_o ports).
//
//  Ports    :
//    clk_i, rst_ni             clock (rising edge), async active-low reset
//    imem_req_i/addr_i         I address phase (read only)
//    imem_gnt_o                I address phase accepted
//    imem_rvalid_o/rdata_o     I response
//    dmem_req_i/we_i/be_i/
//    addr_i/wdata_i            D address phase
//    dmem_gnt_o                D address phase accepted
//    dmem_rvalid_o/rdata_o     D response (reads and writes)
//    bus_req_o/we_o/be_o/
//    addr_o/wdata_o            bus address phase
//    bus_gnt_i                 bus accepted the address phase
//    bus_rvalid_i/rdata_i      bus response
//    rsp_err_o                 sticky: response arrived with no outstanding ID
//    perf_i_gnt_o, perf_d_gnt_o, perf_conflict_o  (ARB_PERF_COUNTERS_EN only)
// ============================================================================
module mem_port_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        imem_req_i,
   input  logic [63:0] imem_addr_i,
   output logic        imem_gnt_o,
   output logic        imem_rvalid_o,
   output logic [63:0] imem_rdata_o,
   input  logic        dmem_req_i,
   input  logic        dmem_we_i,
   input  logic [7:0]  dmem_be_i,
   input  logic [63:0] dmem_addr_i,
   input  logic [63:0] dmem_wdata_i,
   output logic        dmem_gnt_o,
   output logic        dmem_rvalid_o,
   output logic [63:0] dmem_rdata_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [7:0]  bus_be_o,
   output logic [63:0] bus_addr_o,
   output logic [63:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [63:0] bus_rdata_i,
   output logic        rsp_err_o
`ifdef ARB_PERF_COUNTERS_EN
   ,
   output logic [31:0] perf_i_gnt_o,
   output logic [31:0] perf_d_gnt_o,
   output logic [31:0] perf_conflict_o
`endif
);

   localparam int unsigned      PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned      CNT_W      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
   localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } sel_e;

   sel_e                 sel_q, sel_d;
   logic                 lock_q, lock_d;
   logic [3:0]           starve_cnt_q, starve_cnt_d;
   // One owner bit per FIFO slot: 1 = D, 0 = I.
   logic [MAX_OUTSTANDING-1:0] id_q, id_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 rsp_err_q, rsp_err_d;

   logic                 fifo_empty;
   logic                 fifo_room;
   logic                 sel_req;
   logic                 grant;
   logic                 push;
   logic                 pop;
   logic                 head_is_d;

   // -------------------------------------------------------------------------
   // Selection. While locked the previous choice is held so the bus sees a
   // stable address phase until it grants.
   // -------------------------------------------------------------------------
   always_comb begin
      sel_d = SEL_I;
      if (lock_q) begin
         sel_d = sel_q;
      end else if ((starve_cnt_q == STARVE_MAX) && imem_req_i) begin
         sel_d = SEL_I;
      end else if (dmem_req_i) begin
         sel_d = SEL_D;
      end else begin
         sel_d = SEL_I;
      end
   end

   assign fifo_empty = (count_q == '0);
   // A response retiring in this cycle frees the slot a same-cycle grant needs.
   assign fifo_room  = (count_q != FULL_CNT) || bus_rvalid_i;

   assign sel_req    = (sel_d == SEL_D) ? dmem_req_i : imem_req_i;
   // Gating with rst_ni keeps the bus quiet during reset even though the
   // FIFO reads empty (not full) while reset is held.
   assign bus_req_o  = rst_ni & sel_req & fifo_room;
   assign grant      = bus_req_o & bus_gnt_i;

   assign imem_gnt_o = grant & (sel_d == SEL_I);
   assign dmem_gnt_o = grant & (sel_d == SEL_D);

   assign bus_we_o    = (sel_d == SEL_D) ? dmem_we_i    : 1'b0;
   assign bus_be_o    = (sel_d == SEL_D) ? dmem_be_i    : 8'hFF;
   assign bus_addr_o  = (sel_d == SEL_D) ? dmem_addr_i  : imem_addr_i;
   assign bus_wdata_o = (sel_d == SEL_D) ? dmem_wdata_i : 64'h0;

   // -------------------------------------------------------------------------
   // Response steering: only rvalid is routed, data is broadcast.
   // -------------------------------------------------------------------------
   assign push          = grant;
   assign pop           = rst_ni & bus_rvalid_i & ~fifo_empty;
   assign head_is_d     = id_q[rd_ptr_q];
   assign imem_rvalid_o = pop & ~head_is_d;
   assign dmem_rvalid_o = pop &  head_is_d;
   assign imem_rdata_o  = bus_rdata_i;
   assign dmem_rdata_o  = bus_rdata_i;
   assign rsp_err_o     = rsp_err_q;

   always_comb begin
      id_d     = id_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // When full with push and pop together, wr_ptr equals rd_ptr: the
      // head bit is consumed from id_q this cycle before being overwritten.
      if (push) begin
         id_d[wr_ptr_q] = (sel_d == SEL_D);
         wr_ptr_d       = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      lock_d = lock_q;
      if (grant) begin
         lock_d = 1'b0;
      end else if (bus_req_o) begin
         lock_d = 1'b1;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!imem_req_i || imem_gnt_o) begin
         starve_cnt_d = '0;
      end else if (dmem_gnt_o && (starve_cnt_q != STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   assign rsp_err_d = rsp_err_q | (bus_rvalid_i & fifo_empty);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sel_q        <= SEL_I;
         lock_q       <= 1'b0;
         starve_cnt_q <= '0;
         id_q         <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         sel_q        <= sel_d;
         lock_q       <= lock_d;
         starve_cnt_q <= starve_cnt_d;
         id_q         <= id_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

`ifdef ARB_PERF_COUNTERS_EN
   logic [31:0] perf_i_q;
   logic [31:0] perf_d_q;
   logic [31:0] perf_conflict_q;

   // Counters wrap naturally at 2^32.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_i_q        <= '0;
         perf_d_q        <= '0;
         perf_conflict_q <= '0;
      end else begin
         if (imem_gnt_o) begin
            perf_i_q <= perf_i_q + 32'd1;
         end
         if (dmem_gnt_o) begin
            perf_d_q <= perf_d_q + 32'd1;
         end
         if (imem_req_i && dmem_req_i && bus_req_o) begin
            perf_conflict_q <= perf_conflict_q + 32'd1;
         end
      end
   end

   assign perf_i_gnt_o    = perf_i_q;
   assign perf_d_gnt_o    = perf_d_q;
   assign perf_conflict_o = perf_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Each cycle the bench
//             states the expected arbitration outcome; every predicted grant
//             pushes its owner and response data into a scoreboard queue,
//             which is popped and compared when the bus returns the response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int unsigned MAX_OUT = 2;
   localparam int unsigned STARVE  = 4;
   localparam logic [63:0] IADDR   = 64'h0000_0000_0000_1000;
   localparam logic [63:0] DADDR   = 64'h0000_0000_8000_0040;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        imem_req_i;
   logic [63:0] imem_addr_i;
   logic        imem_gnt_o;
   logic        imem_rvalid_o;
   logic [63:0] imem_rdata_o;
   logic        dmem_req_i;
   logic        dmem_we_i;
   logic [7:0]  dmem_be_i;
   logic [63:0] dmem_addr_i;
   logic [63:0] dmem_wdata_i;
   logic        dmem_gnt_o;
   logic        dmem_rvalid_o;
   logic [63:0] dmem_rdata_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [7:0]  bus_be_o;
   logic [63:0] bus_addr_o;
   logic [63:0] bus_wdata_o;
   logic        bus_gnt_i;
   logic        bus_rvalid_i;
   logic [63:0] bus_rdata_i;
   logic        rsp_err_o;
`ifdef ARB_PERF_COUNTERS_EN
   logic [31:0] perf_i_gnt_o;
   logic [31:0] perf_d_gnt_o;
   logic [31:0] perf_conflict_o;
`endif

   mem_port_arbiter #(
      .MAX_OUTSTANDING (MAX_OUT),
      .STARVE_LIMIT    (STARVE)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .imem_req_i      (imem_req_i),
      .imem_addr_i     (imem_addr_i),
      .imem_gnt_o      (imem_gnt_o),
      .imem_rvalid_o   (imem_rvalid_o),
      .imem_rdata_o    (imem_rdata_o),
      .dmem_req_i      (dmem_req_i),
      .dmem_we_i       (dmem_we_i),
      .dmem_be_i       (dmem_be_i),
      .dmem_addr_i     (dmem_addr_i),
      .dmem_wdata_i    (dmem_wdata_i),
      .dmem_gnt_o      (dmem_gnt_o),
      .dmem_rvalid_o   (dmem_rvalid_o),
      .dmem_rdata_o    (dmem_rdata_o),
      .bus_req_o       (bus_req_o),
      .bus_we_o        (bus_we_o),
      .bus_be_o        (bus_be_o),
      .bus_addr_o      (bus_addr_o),
      .bus_wdata_o     (bus_wdata_o),
      .bus_gnt_i       (bus_gnt_i),
      .bus_rvalid_i    (bus_rvalid_i),
      .bus_rdata_i     (bus_rdata_i),
      .rsp_err_o       (rsp_err_o)
`ifdef ARB_PERF_COUNTERS_EN
      ,
      .perf_i_gnt_o    (perf_i_gnt_o),
      .perf_d_gnt_o    (perf_d_gnt_o),
      .perf_conflict_o (perf_conflict_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        is_d;
      logic [63:0] data;
   } rsp_t;

   rsp_t        sb_q[$];
   int unsigned vec_cnt = 0;
   int unsigned err_cnt = 0;
   logic [63:0] next_rdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One bus cycle. Inputs are applied just after a rising edge, outputs are
   // checked on the falling edge. exp_sel: 0 = I selected, 1 = D selected.
   task automatic step(input logic ireq, input logic dreq, input logic gnt, input logic rv,
                       input logic exp_breq, input logic exp_sel);
      logic have_rsp;
      logic exp_ig;
      logic exp_dg;
      rsp_t e;
      e            = '0;
      imem_req_i   = ireq;
      dmem_req_i   = dreq;
      bus_gnt_i    = gnt;
      bus_rvalid_i = rv;
      have_rsp     = rv && (sb_q.size() > 0);
      if (have_rsp) begin
         e           = sb_q.pop_front();
         bus_rdata_i = e.data;
      end else begin
         bus_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
      end
      @(negedge clk_i);
      exp_ig = exp_breq & gnt & ~exp_sel;
      exp_dg = exp_breq & gnt &  exp_sel;
      chk("bus_req",  64'(bus_req_o),  64'(exp_breq));
      chk("imem_gnt", 64'(imem_gnt_o), 64'(exp_ig));
      chk("dmem_gnt", 64'(dmem_gnt_o), 64'(exp_dg));
      if (exp_breq) begin
         chk("bus_addr",  bus_addr_o,       exp_sel ? dmem_addr_i : imem_addr_i);
         chk("bus_we",    64'(bus_we_o),    exp_sel ? 64'(dmem_we_i) : 64'h0);
         chk("bus_be",    64'(bus_be_o),    exp_sel ? 64'(dmem_be_i) : 64'hFF);
         chk("bus_wdata", bus_wdata_o,      exp_sel ? dmem_wdata_i : 64'h0);
      end
      if (have_rsp) begin
         chk("rvalid_route", 64'({imem_rvalid_o, dmem_rvalid_o}), e.is_d ? 64'd1 : 64'd2);
         chk("rdata", e.is_d ? dmem_rdata_o : imem_rdata_o, e.data);
      end else begin
         chk("rvalid_none", 64'({imem_rvalid_o, dmem_rvalid_o}), 64'd0);
      end
      if (exp_ig || exp_dg) begin
         sb_q.push_back('{is_d: exp_dg, data: next_rdata});
         next_rdata = next_rdata + 64'd1;
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni       = 1'b0;
      imem_addr_i  = IADDR;
      dmem_addr_i  = DADDR;
      dmem_we_i    = 1'b1;
      dmem_be_i    = 8'h0F;
      dmem_wdata_i = 64'h1122_3344_5566_7788;
      bus_rdata_i  = 64'h0;
      next_rdata   = 64'h0;
      // Requests and bus strobes high during reset must not leak through.
      imem_req_i   = 1'b1;
      dmem_req_i   = 1'b1;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_bus_req", 64'(bus_req_o), 64'd0);
      chk("rst_gnt",     64'({imem_gnt_o, dmem_gnt_o}), 64'd0);
      chk("rst_rvalid",  64'({imem_rvalid_o, dmem_rvalid_o}), 64'd0);
      chk("rst_err",     64'(rsp_err_o), 64'd0);
      imem_req_i   = 1'b0;
      dmem_req_i   = 1'b0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      rst_ni       = 1'b1;
      @(posedge clk_i);
      #1;

      // Single I read, granted at once, answered two cycles later.
      next_rdata = 64'hDEAD;
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Both request, bus grants and answers every cycle: D D D D I D, then I.
      next_rdata = 64'h2000;
      dmem_we_i  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 1'b1, (i > 0), 1'b1, (i == 4) ? 1'b0 : 1'b1);
      end
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // I waits three cycles for the bus; D arriving meanwhile cannot steal it.
      next_rdata  = 64'h3000;
      dmem_addr_i = 64'h0000_0000_8000_0100;
      dmem_be_i   = 8'hF0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // FIFO full blocks a third D; a same-cycle response lets it through
      // and the FIFO stays full afterwards.
      next_rdata   = 64'h4000;
      dmem_we_i    = 1'b1;
      dmem_wdata_i = 64'hCAFE_F00D_0000_0004;
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Stray response with an empty FIFO sets the sticky error.
      chk("err_before", 64'(rsp_err_o), 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("err_set", 64'(rsp_err_o), 64'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("err_held", 64'(rsp_err_o), 64'd1);

      // Asynchronous reset with two transactions outstanding.
      next_rdata = 64'h5000;
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      dmem_req_i = 1'b1;
      bus_gnt_i  = 1'b1;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_rst_err",     64'(rsp_err_o), 64'd0);
      chk("async_rst_bus_req", 64'(bus_req_o), 64'd0);
      chk("async_rst_gnt",     64'(dmem_gnt_o), 64'd0);
      sb_q.delete();
      @(posedge clk_i);
      #1;
      dmem_req_i = 1'b0;
      bus_gnt_i  = 1'b0;
      rst_ni     = 1'b1;
      // The discarded IDs must not route this late response anywhere.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("late_rsp_err", 64'(rsp_err_o), 64'd1);

      // Fresh reset, then 3 I grants, 5 D grants, 2 conflict cycles.
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      chk("rst2_err", 64'(rsp_err_o), 64'd0);
`ifdef ARB_PERF_COUNTERS_EN
      chk("perf_rst", 64'({perf_i_gnt_o, perf_d_gnt_o}) | 64'(perf_conflict_o), 64'd0);
`endif
      next_rdata = 64'h6000;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ARB_PERF_COUNTERS_EN
      chk("perf_i_gnt",    64'(perf_i_gnt_o),    64'd3);
      chk("perf_d_gnt",    64'(perf_d_gnt_o),    64'd5);
      chk("perf_conflict", 64'(perf_conflict_o), 64'd2);
`endif
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire
